// File: rtl/pci_arb_pkg.sv
// -----------------------------------------------------------------------------
// pci_arb_pkg
// Shared definitions for the round-robin PCI arbiter:
//   - arb_state_e : arbiter FSM states (ARB, PARK, GRANT, BUSY)
//   - IDLE_BUS    : value of {frame_n, irdy_n} when the bus is idle
//   - clog2()     : constant ceil(log2()) used to size pointers and timers
// -----------------------------------------------------------------------------
package pci_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    PARK  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } arb_state_e;

  // {frame_n, irdy_n}: both deasserted means no transaction is in flight.
  localparam logic [1:0] IDLE_BUS = 2'b11;

  // Smallest r with 2**r >= value; returns 1 for value <= 2 so that
  // every counter is at least one bit wide.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pci_rr_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans the active-high request vector
// starting at 'pointer' and moving upward, wrapping from NUM_MASTERS-1 to 0,
// and returns the first requester found.
//   req     in   NUM_MASTERS  active-high requests
//   pointer in   PTR_W        index where the scan starts
//   valid   out  1            at least one request is set
//   index   out  PTR_W        winning master (0 when valid=0)
// -----------------------------------------------------------------------------
module rr_picker
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int PTR_W       = clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       pointer,
  output logic                   valid,
  output logic [PTR_W-1:0]       index
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset back to offset 0 so the candidate
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(pointer) + k) % NUM_MASTERS);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pci_rr_arbiter
// Central PCI bus arbiter with round-robin fairness, bus parking and a grant
// timeout. All outputs are registered. A grant never moves directly from one
// master to another: every change of owner passes through an all-ones cycle.
//   clk           in   1            bus clock, posedge
//   rst           in   1            synchronous active-high reset
//   req_n         in   NUM_MASTERS  active-low requests, bit i = master i
//   frame_n       in   1            PCI FRAME#
//   irdy_n        in   1            PCI IRDY#
//   gnt_n         out  NUM_MASTERS  active-low grants, at most one low
//   owner         out  PTR_W        current or last granted master
//   bus_busy      out  1            FSM is in BUSY
//   timeout_pulse out  1            one cycle when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16,
  parameter int PARK_MASTER = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req_n,
  input  logic                          frame_n,
  input  logic                          irdy_n,
  output logic [NUM_MASTERS-1:0]        gnt_n,
  output logic [clog2(NUM_MASTERS)-1:0] owner,
  output logic                          bus_busy,
  output logic                          timeout_pulse
);

  localparam int PTR_W = clog2(NUM_MASTERS);
  localparam int TMR_W = clog2(TIMEOUT);

  localparam logic [PTR_W-1:0]       PARK_IDX  = PTR_W'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] PARK_MASK = NUM_MASTERS'(1) << PARK_MASTER;
  localparam logic [TMR_W-1:0]       TMR_LAST  = TMR_W'(TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_MASTERS-1:0] gnt_n_d;
  logic [PTR_W-1:0]       owner_d;
  logic                   pulse_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   bus_idle;
  logic                   owner_req;
  logic                   other_req;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       ptr_inc;
  logic [TMR_W-1:0]       timer_inc;

  assign req       = ~req_n;
  assign bus_idle  = ({frame_n, irdy_n} == IDLE_BUS);
  assign owner_req = req[owner];
  assign other_req = |(req & ~PARK_MASK);

  // Next round-robin start: one past the owner, wrapping at NUM_MASTERS.
  assign ptr_inc   = (owner == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

  // Saturate at the terminal count so a stalled timer never wraps to 0.
  assign timer_inc = (timer_q == TMR_LAST) ? timer_q : timer_q + 1'b1;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_picker (
    .req     (req),
    .pointer (ptr_q),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    gnt_n_d = gnt_n;
    owner_d = owner;
    pulse_d = 1'b0;

    unique case (state_q)
      ARB: begin
        gnt_n_d = '1;
        if (bus_idle) begin
          if (pick_valid) begin
            state_d = GRANT;
            gnt_n_d = ~(NUM_MASTERS'(1) << pick_idx);
            owner_d = pick_idx;
            timer_d = '0;
          end else begin
            state_d = PARK;
            gnt_n_d = ~PARK_MASK;
            owner_d = PARK_IDX;
          end
        end
      end

      PARK: begin
        if (!frame_n) begin
          state_d = BUSY;
        end else if (other_req) begin
          // Drop the parked grant first; ARB hands the bus over next cycle.
          state_d = ARB;
          gnt_n_d = '1;
        end else if (req[PARK_MASTER]) begin
          state_d = GRANT;
          timer_d = '0;
        end
      end

      GRANT: begin
        timer_d = timer_inc;
        if (!frame_n) begin
          state_d = BUSY;
          ptr_d   = ptr_inc;
        end else if (!owner_req) begin
          // Withdrawal keeps the pointer so this master is not penalised.
          state_d = ARB;
          gnt_n_d = '1;
        end else if (timer_q == TMR_LAST) begin
          state_d = ARB;
          gnt_n_d = '1;
          ptr_d   = ptr_inc;
          pulse_d = 1'b1;
        end
      end

      BUSY: begin
        if (bus_idle) begin
          state_d = ARB;
          gnt_n_d = '1;
        end else if (!owner_req) begin
          // Once dropped mid-transaction the grant stays off until ARB.
          gnt_n_d = '1;
        end
      end

      default: begin
        state_d = ARB;
        gnt_n_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (rst) begin
      state_q       <= ARB;
      ptr_q         <= '0;
      timer_q       <= '0;
      gnt_n         <= '1;
      owner         <= PARK_IDX;
      bus_busy      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      gnt_n         <= gnt_n_d;
      owner         <= owner_d;
      bus_busy      <= (state_d == BUSY);
      timeout_pulse <= pulse_d;
    end
  end

endmodule
